// File: rtl/branch_predict_ctrl.sv
// Dynamic branch-direction controller: 2-bit counter table lookup in ID,
// resolution in EX, PC redirect/flush generation and branch statistics.
module branch_predict_ctrl #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              id_branch,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_target,
    output logic              id_pred_taken,
    input  logic              ex_branch,
    input  logic [31:0]       ex_pc,
    input  logic              ex_pred_taken,
    input  logic              ex_pcsrc,
    input  logic [31:0]       ex_target,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            cnt_tab_q [ENTRIES];
    logic [1:0]            cnt_tab_d [ENTRIES];
    logic [STAT_W-1:0]     branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0]     mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] id_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic                  id_hit;
    logic                  mispredict;
    logic                  resolve;

    assign id_idx     = id_pc[INDEX_BITS+1:2];
    assign ex_idx     = ex_pc[INDEX_BITS+1:2];
    assign id_hit     = id_branch & cnt_tab_q[id_idx][1];
    assign mispredict = ex_branch & (ex_pcsrc != ex_pred_taken);
    assign resolve    = ex_branch & ~stall;

    // EX mispredict outranks the ID prediction and ignores stall.
    always_comb begin
        id_pred_taken = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        if (!reset) begin
            id_pred_taken = id_hit;
            if (mispredict) begin
                redirect    = 1'b1;
                redirect_pc = ex_pcsrc ? ex_target : ex_pc + 32'd4;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
            end else if (!stall && id_hit) begin
                redirect    = 1'b1;
                redirect_pc = id_target;
                flush_ifid  = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_tab_d     = cnt_tab_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve) begin
            if (ex_pcsrc) begin
                if (cnt_tab_q[ex_idx] != 2'b11)
                    cnt_tab_d[ex_idx] = cnt_tab_q[ex_idx] + 2'b01;
            end else begin
                if (cnt_tab_q[ex_idx] != 2'b00)
                    cnt_tab_d[ex_idx] = cnt_tab_q[ex_idx] - 2'b01;
            end
            if (branch_cnt_q != '1)
                branch_cnt_d = branch_cnt_q + 1'b1;
            if (mispredict && mispred_cnt_q != '1)
                mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                cnt_tab_q[i] <= 2'b01;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            cnt_tab_q     <= cnt_tab_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        id_branch;
    logic [31:0] id_pc, id_target;
    logic        id_pred_taken;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken, ex_pcsrc;
    logic [31:0] ex_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_ifid, flush_idex;
    logic [15:0] branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.INDEX_BITS(4), .STAT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .id_branch(id_branch), .id_pc(id_pc), .id_target(id_target),
        .id_pred_taken(id_pred_taken),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_pcsrc(ex_pcsrc), .ex_target(ex_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    task automatic clear_inputs();
        reset = 1'b0; stall = 1'b0;
        id_branch = 1'b0; id_pc = '0; id_target = '0;
        ex_branch = 1'b0; ex_pc = '0; ex_pred_taken = 1'b0;
        ex_pcsrc = 1'b0; ex_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic e_pred, input logic e_redir,
                              input logic [31:0] e_pc, input logic e_fi, input logic e_fx);
        checks++;
        if ({id_pred_taken, redirect, redirect_pc, flush_ifid, flush_idex} !==
            {e_pred, e_redir, e_pc, e_fi, e_fx}) begin
            errors++;
            $display("FAIL %s: got pred=%b redir=%b pc=%h fi=%b fx=%b, want pred=%b redir=%b pc=%h fi=%b fx=%b",
                     name, id_pred_taken, redirect, redirect_pc, flush_ifid, flush_idex,
                     e_pred, e_redir, e_pc, e_fi, e_fx);
        end
    endtask

    task automatic check_state(input string name, input int idx, input logic [1:0] e_ctr,
                               input logic [15:0] e_br, input logic [15:0] e_mp);
        checks++;
        if (dut.cnt_tab_q[idx] !== e_ctr || branch_cnt !== e_br || mispred_cnt !== e_mp) begin
            errors++;
            $display("FAIL %s: got entry[%0d]=%b br=%h mp=%h, want %b br=%h mp=%h",
                     name, idx, dut.cnt_tab_q[idx], branch_cnt, mispred_cnt, e_ctr, e_br, e_mp);
        end
    endtask

    task automatic check_all_reset(input string name);
        for (int i = 0; i < 16; i++) check_state(name, i, 2'b01, 16'h0, 16'h0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic pred, input logic taken,
                           input logic [31:0] tgt);
        ex_branch = 1'b1; ex_pc = pc; ex_pred_taken = pred; ex_pcsrc = taken; ex_target = tgt;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        id_branch = 1'b1; id_pc = 32'h40; id_target = 32'h100;
        resolve(32'h40, 1'b0, 1'b1, 32'h100);
        #1 check_outs("reset_outs", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        check_all_reset("reset_state");
        id_branch = 1'b1; id_pc = 32'h40;
        #1 check_outs("first_lookup", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b0;
    endtask

    task automatic test_mispredict_taken();
        resolve(32'h40, 1'b0, 1'b1, 32'h100);
        #1 check_outs("mispred_taken", 1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        tick();
        clear_inputs();
        check_state("after_mispred", 0, 2'b10, 16'd1, 16'd1);
    endtask

    task automatic test_predict_taken();
        id_branch = 1'b1; id_pc = 32'h40; id_target = 32'h100;
        #1 check_outs("id_taken", 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        id_pc = 32'h44; id_target = 32'h200;
        #1 check_outs("id_not_taken", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b0; id_pc = 32'h40;
        #1 check_outs("id_no_branch", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("lookup_no_effect", 0, 2'b10, 16'd1, 16'd1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            resolve(32'h40, 1'b1, 1'b1, 32'h100);
            #1 check_outs("correct_taken", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        clear_inputs();
        check_state("saturated", 0, 2'b11, 16'd5, 16'd1);
        // same-cycle lookup of the entry being updated sees the old value
        resolve(32'h40, 1'b1, 1'b0, 32'h100);
        id_branch = 1'b1; id_pc = 32'h40; id_target = 32'h300;
        #1 check_outs("mispred_not_taken", 1'b1, 1'b1, 32'h44, 1'b1, 1'b1);
        tick();
        clear_inputs();
        check_state("after_not_taken", 0, 2'b10, 16'd6, 16'd2);
    endtask

    task automatic test_priority();
        resolve(32'h48, 1'b1, 1'b0, 32'h500);
        id_branch = 1'b1; id_pc = 32'h1040; id_target = 32'h900;
        #1 check_outs("ex_over_id", 1'b1, 1'b1, 32'h4C, 1'b1, 1'b1);
        tick();
        clear_inputs();
        check_state("prio_entry2", 2, 2'b00, 16'd7, 16'd3);
        check_state("prio_entry0", 0, 2'b10, 16'd7, 16'd3);
        resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h10);
        #1 check_outs("pc_wrap", 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        tick();
        clear_inputs();
        check_state("wrap_entry15", 15, 2'b00, 16'd8, 16'd4);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        resolve(32'h40, 1'b1, 1'b1, 32'h100);
        id_branch = 1'b1; id_pc = 32'h40; id_target = 32'h100;
        #1 check_outs("stall_no_id_redirect", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("stall_no_update", 0, 2'b10, 16'd8, 16'd4);
        resolve(32'h44, 1'b0, 1'b1, 32'h200);
        #1 check_outs("stall_mispred", 1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        tick();
        clear_inputs();
        check_state("stall_mispred_entry1", 1, 2'b01, 16'd8, 16'd4);
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        resolve(32'h40, 1'b0, 1'b1, 32'h100);
        #1 check_outs("mid_reset_outs", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        check_all_reset("mid_reset_state");
    endtask

    task automatic test_stat_saturate();
        resolve(32'h40, 1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 65535; i++) @(posedge clk);
        #1;
        check_state("stats_at_max", 0, 2'b11, 16'hFFFF, 16'hFFFF);
        tick();
        clear_inputs();
        check_state("stats_hold", 0, 2'b11, 16'hFFFF, 16'hFFFF);
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_mispredict_taken();
        test_predict_taken();
        test_saturate();
        test_priority();
        test_stall();
        test_reset_mid();
        test_stat_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Dynamic branch-direction controller for the 5-stage RV32I pipeline.
- Predicts conditional branches in ID with a table of 2-bit saturating counters indexed by PC.
- Resolves each prediction in EX against the branch-unit PCSrc result.
- Drives PC redirect and IF/ID and ID/EX flushes, and keeps branch/mispredict statistics.

Parameters:
- INDEX_BITS, 4, log2 of counter-table entries; index = pc[INDEX_BITS+1:2].
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline freeze; blocks all table/stat updates and ID redirects.
- id_branch  in  1  instruction in ID is a conditional branch (opcode 1100011).
- id_pc  in  32  PC of the ID instruction.
- id_target  in  32  branch target computed in ID (pc + imm_b).
- id_pred_taken  out  1  prediction for the ID instruction; carried down the pipeline to EX.
- ex_branch  in  1  instruction in EX is a conditional branch.
- ex_pc  in  32  PC of the EX instruction.
- ex_pred_taken  in  1  prediction that was made for the EX instruction.
- ex_pcsrc  in  1  actual outcome, from the branch unit (PCSrc).
- ex_target  in  32  resolved taken target.
- redirect  out  1  load redirect_pc into the PC at the next edge.
- redirect_pc  out  32  new fetch address.
- flush_ifid  out  1  squash the IF/ID register at the next edge.
- flush_idex  out  1  squash the ID/EX register at the next edge.
- branch_cnt  out  STAT_W  resolved branches.
- mispred_cnt  out  STAT_W  mispredicted branches.

Behaviour:
- Table: 2^INDEX_BITS entries, 2 bits each. Encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset: every entry becomes 01 in one cycle. branch_cnt and mispred_cnt become 0.
- While reset is high: redirect, flush_ifid, flush_idex, id_pred_taken = 0; redirect_pc = 0.
- Prediction, combinational, 0-cycle latency: id_pred_taken = id_branch & table[id_idx][1]. It reads pre-edge state.
- Same-cycle update and lookup of the same index: the lookup returns the old value. There is no bypass.
- Resolution in EX, combinational: mispredict = ex_branch & (ex_pcsrc != ex_pred_taken).
- Mispredict response, same cycle:
  - redirect = 1, flush_ifid = 1, flush_idex = 1.
  - redirect_pc = ex_target if ex_pcsrc = 1, else ex_pc + 4 (32-bit wrap).
  - Mispredict ignores stall: a redirect always wins over a freeze.
- ID taken-prediction response, when there is no mispredict and stall = 0:
  - If id_pred_taken = 1: redirect = 1, redirect_pc = id_target, flush_ifid = 1, flush_idex = 0.
- Priority: an EX mispredict overrides an ID prediction in the same cycle. The ID instruction is squashed, and its lookup is discarded with no side effect.
- Table update at the edge, when ex_branch = 1 and stall = 0:
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
  - The update uses ex_pc's index.
- Stats at the edge, when ex_branch = 1 and stall = 0:
  - branch_cnt increments.
  - mispred_cnt increments if mispredict.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: reset dominates any pending update. The table and stats return to their reset state at that edge, regardless of ex_branch.
- Aliasing: PCs differing only above bit INDEX_BITS+1 share an entry. This is intended and there is no tag check.

Test Plan:
1. Reset, then id_branch = 1, id_pc = 0x40 → id_pred_taken = 0, redirect = 0. Entry 0 reads 01.
2. Branch at 0x40 resolved taken with ex_pred_taken = 0, ex_target = 0x100 → in that cycle redirect = 1, redirect_pc = 0x100, flush_ifid = flush_idex = 1. Next cycle entry 0 = 10, branch_cnt = 1, mispred_cnt = 1.
3. Lookup at 0x40 after step 2 with id_target = 0x100 → id_pred_taken = 1, redirect = 1, redirect_pc = 0x100, flush_ifid = 1, flush_idex = 0.
4. Resolve 0x40 taken four more times → counter saturates at 11. Then resolve not-taken with ex_pred_taken = 1 → redirect_pc = 0x44, counter = 10.
5. EX mispredict and ID taken prediction in the same cycle → redirect_pc is the EX value, and flush_idex = 1.
6. stall = 1 with ex_branch = 1 and a correct prediction → no table or stat change. Then assert reset mid-run → all entries 01, both counters 0. Also drive 0xFFFF+1 branches → branch_cnt holds at 0xFFFF.
